// File: rtl/sop_equiv_pkg.sv
// Shared types and helpers for the SOP equivalence checker: FSM states,
// pipeline depth and the single-cube match function.
package sop_equiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIPE_LAT = 2;
  localparam int MAX_N    = 12;

  // A cube matches when every cared-for literal equals its required value;
  // narrower callers zero-extend, which leaves the unused bits don't-care.
  function automatic logic cube_hit(input logic [MAX_N-1:0] vec,
                                    input logic [MAX_N-1:0] care,
                                    input logic [MAX_N-1:0] val);
    return ((vec ^ val) & care) == '0;
  endfunction

endpackage

// File: rtl/sop_eval_stage.sv
// Two-stage evaluator for one sum-of-products expression: registered term
// hits, then their registered OR.
module sop_eval_stage
  import sop_equiv_pkg::*;
#(
  parameter int N = 3,
  parameter int T = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   vec,
  input  logic [T*N-1:0] care,
  input  logic [T*N-1:0] val,
  input  logic [T-1:0]   en,
  output logic           f
);

  logic [T-1:0] hit_next;
  logic [T-1:0] hit_reg;

  for (genvar gi = 0; gi < T; gi++) begin : g_term
    assign hit_next[gi] = en[gi] &&
                          cube_hit(MAX_N'(vec), MAX_N'(care[gi*N +: N]), MAX_N'(val[gi*N +: N]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_reg <= '0;
      f       <= 1'b0;
    end else begin
      hit_reg <= hit_next;
      f       <= |hit_reg;
    end
  end

endmodule

// File: rtl/sop_equiv_checker.sv
// Sweeps all 2^N input vectors through two SOP evaluators and reports the
// first vector where they disagree, or equality after the last vector.
module sop_equiv_checker
  import sop_equiv_pkg::*;
#(
  parameter int N = 3,
  parameter int T = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [T*N-1:0] a_care,
  input  logic [T*N-1:0] a_val,
  input  logic [T-1:0]   a_en,
  input  logic [T*N-1:0] b_care,
  input  logic [T*N-1:0] b_val,
  input  logic [T-1:0]   b_en,
  output logic           busy,
  output logic           done,
  output logic           equal,
  output logic [N-1:0]   mismatch_vec,
  output logic           fa_at_mis,
  output logic           fb_at_mis
);

  state_t               state;
  logic [N-1:0]         cnt;
  logic [T*N-1:0]       a_care_reg, a_val_reg, b_care_reg, b_val_reg;
  logic [T-1:0]         a_en_reg, b_en_reg;
  logic [PIPE_LAT-1:0]  vld_reg;
  logic [N-1:0]         vec_pipe [PIPE_LAT];
  logic                 fa, fb;
  logic                 issue, mis, last_out;

  sop_eval_stage #(.N(N), .T(T)) u_eval_a (
    .clk(clk), .rst_n(rst_n), .vec(cnt),
    .care(a_care_reg), .val(a_val_reg), .en(a_en_reg), .f(fa)
  );

  sop_eval_stage #(.N(N), .T(T)) u_eval_b (
    .clk(clk), .rst_n(rst_n), .vec(cnt),
    .care(b_care_reg), .val(b_val_reg), .en(b_en_reg), .f(fb)
  );

  assign issue    = (state == SWEEP);
  assign mis      = vld_reg[PIPE_LAT-1] && (fa != fb);
  // The oldest entry is the last one when nothing younger is in flight.
  assign last_out = vld_reg[PIPE_LAT-1] && !(|vld_reg[PIPE_LAT-2:0]);

  // Shadow pipeline tracks which vector each evaluator stage is holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int i = 0; i < PIPE_LAT; i++) vec_pipe[i] <= '0;
    end else begin
      vld_reg     <= mis ? '0 : {vld_reg[PIPE_LAT-2:0], issue};
      vec_pipe[0] <= cnt;
      for (int i = 1; i < PIPE_LAT; i++) vec_pipe[i] <= vec_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      a_care_reg   <= '0;
      a_val_reg    <= '0;
      a_en_reg     <= '0;
      b_care_reg   <= '0;
      b_val_reg    <= '0;
      b_en_reg     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      mismatch_vec <= '0;
      fa_at_mis    <= 1'b0;
      fb_at_mis    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_care_reg   <= a_care;
            a_val_reg    <= a_val;
            a_en_reg     <= a_en;
            b_care_reg   <= b_care;
            b_val_reg    <= b_val;
            b_en_reg     <= b_en;
            cnt          <= '0;
            equal        <= 1'b0;
            mismatch_vec <= '0;
            fa_at_mis    <= 1'b0;
            fb_at_mis    <= 1'b0;
            busy         <= 1'b1;
            state        <= SWEEP;
          end
        end
        SWEEP, DRAIN: begin
          if (mis) begin
            mismatch_vec <= vec_pipe[PIPE_LAT-1];
            fa_at_mis    <= fa;
            fb_at_mis    <= fb;
            equal        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else if (state == DRAIN && last_out) begin
            equal <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (state == SWEEP) begin
            if (cnt == '1) state <= DRAIN;
            else           cnt   <= cnt + N'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sop_equiv_checker.sv
// Directed bench: table of N=3 cube-list pairs with hand-computed results,
// plus N=1 constant case, held-start/config-toggle and mid-sweep reset.
module tb_sop_equiv_checker;

  typedef struct {
    string      name;
    logic [8:0] a_care, a_val, b_care, b_val;
    logic [2:0] a_en, b_en;
    int         exp_edge;
    logic       exp_eq;
    logic [2:0] exp_vec;
    logic       exp_fa, exp_fb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start3 = 1'b0;
  logic [8:0] a_care = '0, a_val = '0, b_care = '0, b_val = '0;
  logic [2:0] a_en = '0, b_en = '0;
  logic       busy3, done3, equal3, fa3, fb3;
  logic [2:0] mvec3;

  logic       start1 = 1'b0;
  logic       a_care1 = 1'b0, a_val1 = 1'b0, a_en1 = 1'b0;
  logic       b_care1 = 1'b0, b_val1 = 1'b0, b_en1 = 1'b0;
  logic       busy1, done1, equal1, fa1, fb1;
  logic [0:0] mvec1;

  int tests = 0;
  int fails = 0;
  vec_t tbl [5];

  always #5 clk = ~clk;

  sop_equiv_checker #(.N(3), .T(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .a_care(a_care), .a_val(a_val), .a_en(a_en),
    .b_care(b_care), .b_val(b_val), .b_en(b_en),
    .busy(busy3), .done(done3), .equal(equal3),
    .mismatch_vec(mvec3), .fa_at_mis(fa3), .fb_at_mis(fb3)
  );

  sop_equiv_checker #(.N(1), .T(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a_care(a_care1), .a_val(a_val1), .a_en(a_en1),
    .b_care(b_care1), .b_val(b_val1), .b_en(b_en1),
    .busy(busy1), .done(done1), .equal(equal1),
    .mismatch_vec(mvec1), .fa_at_mis(fa1), .fb_at_mis(fb1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    a_care = v.a_care; a_val = v.a_val; a_en = v.a_en;
    b_care = v.b_care; b_val = v.b_val; b_en = v.b_en;
  endtask

  // Caller guarantees the DUT is in IDLE; the edge after start is raised is E0.
  task automatic run3(input vec_t v);
    int de;
    de = -1;
    set_cfg(v);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    check({v.name, " busy after E0"}, 32'(busy3), 1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done3) begin de = k; break; end
    end
    check({v.name, " done edge"}, 32'(de), 32'(v.exp_edge));
    if (de >= 0) check({v.name, " busy at done"}, 32'(busy3), 0);
    check({v.name, " equal"}, 32'(equal3), 32'(v.exp_eq));
    check({v.name, " mismatch_vec"}, 32'(mvec3), 32'(v.exp_vec));
    check({v.name, " fa_at_mis"}, 32'(fa3), 32'(v.exp_fa));
    check({v.name, " fb_at_mis"}, 32'(fb3), 32'(v.exp_fb));
    $display("[TB] %s: done@E%0d equal=%0d vec=%0d fa=%0d fb=%0d",
             v.name, de, equal3, mvec3, fa3, fb3);
    @(posedge clk); #1;
    check({v.name, " done pulse width"}, 32'(done3), 0);
  endtask

  initial begin
    int d1, d2, ndone;
    logic eq1, eq2;
    logic saw_done;

    // A = A'C' + ABC + AC' ; B = C' + ABC (third term off)
    tbl[0] = '{"equivalent", 9'b101_111_101, 9'b100_111_000, 9'b000_111_001, 9'b000_111_000,
               3'b111, 3'b011, 10, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{"late_mismatch", 9'b101_111_101, 9'b100_111_000, 9'b000_111_001, 9'b000_111_000,
               3'b111, 3'b001, 10, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[2] = '{"early_mismatch", 9'b101_111_101, 9'b100_111_000, 9'b000_111_001, 9'b000_111_000,
               3'b111, 3'b000, 3, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[3] = '{"a_empty_vs_cbar", 9'b101_111_101, 9'b100_111_000, 9'b000_111_001, 9'b000_111_000,
               3'b000, 3'b001, 3, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[4] = '{"abar_cbar_vs_cbar", 9'b101_111_101, 9'b100_111_000, 9'b000_111_001, 9'b000_111_000,
               3'b001, 3'b001, 7, 1'b0, 3'd4, 1'b0, 1'b1};

    #12;
    check("reset busy", 32'(busy3), 0);
    check("reset done", 32'(done3), 0);
    check("reset equal", 32'(equal3), 0);
    check("reset mismatch_vec", 32'(mvec3), 0);
    check("reset fa/fb", 32'({fa3, fb3}), 0);
    check("reset n1 outputs", 32'({busy1, done1, equal1, mvec1, fa1, fb1}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run3(tbl[i]);

    // N=1, both expressions a single enabled care-free term: constant 1.
    begin
      int de;
      de = -1;
      a_care1 = 1'b0; a_val1 = 1'b0; a_en1 = 1'b1;
      b_care1 = 1'b0; b_val1 = 1'b1; b_en1 = 1'b1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("n1 busy after E0", 32'(busy1), 1);
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (done1) begin de = k; break; end
      end
      check("n1 done edge", 32'(de), 4);
      check("n1 equal", 32'(equal1), 1);
      check("n1 mismatch_vec", 32'(mvec1), 0);
      $display("[TB] n1_const1: done@E%0d equal=%0d vec=%0d", de, equal1, mvec1);
      @(posedge clk); #1;
    end

    // start held high; config scrambled mid-sweep then restored before re-accept.
    set_cfg(tbl[0]);
    start3 = 1'b1;
    @(posedge clk); #1;
    d1 = -1; d2 = -1; ndone = 0; eq1 = 1'b0; eq2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin a_en = 3'b010; b_en = 3'b000; b_care = '0; end
      if (k == 7) set_cfg(tbl[0]);
      if (done3) begin
        ndone++;
        if (d1 < 0) begin d1 = k; eq1 = equal3; end
        else begin d2 = k; eq2 = equal3; start3 = 1'b0; break; end
      end
    end
    check("held first done edge", 32'(d1), 10);
    check("held first equal", 32'(eq1), 1);
    check("held second done edge", 32'(d2), 22);
    check("held second equal", 32'(eq2), 1);
    check("held done count", 32'(ndone), 2);
    $display("[TB] held_start: done@E%0d,E%0d equal=%0d,%0d", d1, d2, eq1, eq2);
    @(posedge clk); #1;

    // Reset in the middle of a sweep.
    set_cfg(tbl[0]);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy3), 1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy3), 0);
    check("async reset done/equal", 32'({done3, equal3}), 0);
    check("async reset mis fields", 32'({mvec3, fa3, fb3}), 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done3) saw_done = 1'b1;
    end
    check("no done during reset", 32'(saw_done), 0);
    $display("[TB] mid_sweep_reset: busy=%0d done_seen=%0d", busy3, saw_done);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run3(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sop_equiv_checker.md
# sop_equiv_checker

Sequential, parametrised equivalence checker for two programmable N-input sum-of-products expressions, A and B. On `start` it latches both cube lists and sweeps all 2^N input vectors through a 2-stage pipeline. It stops at the first vector where the two outputs differ, or after the last vector if they never differ. It is the generalised, self-checking successor of the fixed 3-input original-vs-simplified expression pair, and sits on the logic-minimisation verification path.

## Interface
- N, default 3: number of expression inputs (1..12); vector bit N-1 is the most significant input (A for N=3), bit 0 the least (C).
- T, default 4: maximum product terms per expression (1..16).
- Clock is single: `clk`. Reset is `rst_n`, asynchronous, active-low.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  async active-low reset.
- start  in  1  begin a check; sampled only in IDLE.
- a_care  in  T*N  term t uses bits [t*N +: N]; 1 = the literal participates in term t.
- a_val  in  T*N  required literal value where care=1.
- a_en  in  T  term enable for expression A.
- b_care, b_val, b_en  in  T*N, T*N, T  same encoding for expression B.
- busy  out  1  high from the start-accept edge until the edge at which done rises.
- done  out  1  one-cycle pulse when a result is available.
- equal  out  1  1 = no mismatch found; held until the next accepted start.
- mismatch_vec  out  N  first failing vector; 0 when equal=1.
- fa_at_mis, fb_at_mis  out  1  values of A and B at mismatch_vec; 0 when equal=1.

## Operation
- Term hit: ((vec ^ val) & care) == 0, gated by its enable bit. F = OR of all hits.
  - An enabled term with care=0 is constant 1.
  - An expression with no enabled terms is constant 0.
- FSM states:
  - IDLE: on start=1, latch all six config buses, clear result registers, clear the N-bit vector counter, go to SWEEP.
  - SWEEP: issue counter value to stage 1 every cycle and increment. When the issued value is all-ones, go to DRAIN. The counter does not wrap.
  - DRAIN: no new vectors issued; wait for the pipeline to empty.
  - DONE: one cycle. done=1, busy=0, then back to IDLE.
- Compare happens at the stage-2 output. The first valid stage-2 entry with FA != FB:
  - captures mismatch_vec, fa_at_mis and fb_at_mis, and sets equal=0;
  - forces DONE on the next edge and invalidates all younger pipeline entries.
- If all vectors compare equal, equal=1 at done.
- Config input changes after the start-accept edge have no effect.
- start while busy or in DONE is ignored.

## Timing
- E0 is the edge that accepts start.
- Vector k is captured by stage 1 at E(k+1) and by stage 2 at E(k+2), and is compared in the following cycle.
- Mismatch at vector k: done, equal and mismatch fields are valid after E(k+3).
- No mismatch: done after E(2^N+2), i.e. E10 for N=3.
- done and busy never overlap. busy rises after E0.
- Reset values: busy=0, done=0, equal=0, mismatch_vec=0, fa_at_mis=0, fb_at_mis=0, FSM in IDLE, pipeline valids 0.
- Reset mid-sweep aborts the check: no done pulse, all outputs return to their reset values.
- A start presented in the same cycle as done is ignored. It is accepted at the next edge where the FSM is in IDLE.

## Structure
- Package sop_equiv_pkg holds:
  - the FSM state enum (IDLE, SWEEP, DRAIN, DONE);
  - the pipeline depth constant PIPE_LAT=2;
  - the function cube_hit(vec, care, val).
- Sub-module sop_eval_stage (parameters N, T) registers the T term hits (stage 1) and their OR (stage 2) for one expression. It is instantiated twice.
- The top level holds the FSM, the counter, the valid/vector shadow pipeline, the compare logic and the result registers.

## Test plan
- Equivalent pair: N=3, T=3.
  - A = {A'C' (care 101, val 000), ABC (111/111), AC' (101/100)}.
  - B = {C' (001/000), ABC (111/111), third term disabled}.
  - Expect: done after E10, equal=1, mismatch_vec=0.
- Late mismatch: as the equivalent pair, but B drops ABC. Expect done after E10, equal=0, mismatch_vec=7, fa_at_mis=1, fb_at_mis=0.
- Early mismatch: A as the equivalent pair, B all terms disabled. Expect done after E3, mismatch_vec=0, fa_at_mis=1, fb_at_mis=0.
- Constant-1 vs constant-1, N=1: both expressions one enabled term with care=0. Expect done after E4, equal=1.
- start held high throughout, and config toggled mid-sweep: result identical to the equivalent-pair case. The second run begins at the first edge after done.
- rst_n low during SWEEP at cycle 4: all outputs 0 asynchronously, no done pulse. A fresh start afterwards completes normally.
